// File: rtl/bus_owner_arbiter.sv
// bus_owner_arbiter: registered round-robin owner of the CPU bus mux select with hold-time preemption
module bus_owner_arbiter #(
    parameter int NUM_SRC = 24,
    parameter int SEL_W = 5,
    parameter int MAX_HOLD = 4,
    parameter logic [SEL_W-1:0] IDLE_SEL = {SEL_W{1'b1}}
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [NUM_SRC-1:0] req,
    input  logic               lock,
    output logic [NUM_SRC-1:0] gnt,
    output logic [SEL_W-1:0]   bus_sel,
    output logic               bus_busy,
    output logic               preempt
);
    localparam int IW = $clog2(NUM_SRC);
    localparam int HW = $clog2(MAX_HOLD + 1);
    typedef enum logic {IDLE, OWN} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] last_q, last_d, pick;
    logic [HW-1:0] hold_q, hold_d;
    logic [NUM_SRC-1:0] gnt_q, gnt_d, cand;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic busy_q, busy_d, pre_q, pre_d, found;
    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v % NUM_SRC);
    endfunction
    // round-robin scan from last+1; in OWN, last is the owner and is excluded as a contender
    always_comb begin
        cand = req;
        if (state_q == OWN) cand[last_q] = 1'b0;
        found = 1'b0;
        pick = last_q;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (!found && cand[wrap(int'(last_q) + k)]) begin
                found = 1'b1;
                pick = wrap(int'(last_q) + k);
            end
        end
    end
    // next owner: release beats preemption beats keeping; last always tracks the owner
    always_comb begin
        state_d = state_q;
        last_d = last_q;
        hold_d = hold_q;
        pre_d = 1'b0;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = OWN;
                last_d = pick;
                hold_d = HW'(1);
            end
        end else if (!req[last_q]) begin
            state_d = found ? OWN : IDLE;
            last_d = found ? pick : last_q;
            hold_d = found ? HW'(1) : '0;
        end else if (hold_q >= HW'(MAX_HOLD) && !lock && found) begin
            last_d = pick;
            hold_d = HW'(1);
            pre_d = 1'b1;
        end else begin
            hold_d = (hold_q >= HW'(MAX_HOLD)) ? hold_q : hold_q + HW'(1);
        end
        busy_d = state_d == OWN;
        gnt_d = busy_d ? (NUM_SRC'(1) << last_d) : '0;
        sel_d = busy_d ? SEL_W'(last_d) : IDLE_SEL;
    end
    // state and registered outputs; clr starts last at the top so source 0 wins first
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            last_q <= IW'(NUM_SRC - 1);
            hold_q <= '0;
            gnt_q <= '0;
            sel_q <= IDLE_SEL;
            busy_q <= 1'b0;
            pre_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            hold_q <= hold_d;
            gnt_q <= gnt_d;
            sel_q <= sel_d;
            busy_q <= busy_d;
            pre_q <= pre_d;
        end
    end
    assign gnt = gnt_q;
    assign bus_sel = sel_q;
    assign bus_busy = busy_q;
    assign preempt = pre_q;
endmodule

// File: tb/tb_bus_owner_arbiter.sv
// tb_bus_owner_arbiter: vector table, corner sequences and randomized model check of bus_owner_arbiter
module tb_bus_owner_arbiter;
    localparam int N = 24;
    localparam int MH = 4;
    logic clk = 1'b0;
    logic clr, lock;
    logic [N-1:0] req, gnt;
    logic [4:0] bus_sel;
    logic bus_busy, preempt;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic clr;
        logic [N-1:0] req;
        logic lock;
        logic [N-1:0] gnt;
        logic [4:0] sel;
        logic busy;
        logic pre;
    } vec_t;
    vec_t tbl[18];
    int m_owner, m_last, m_hold;
    bit m_pre;

    bus_owner_arbiter dut (
        .clk(clk), .clr(clr), .req(req), .lock(lock),
        .gnt(gnt), .bus_sel(bus_sel), .bus_busy(bus_busy), .preempt(preempt)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] b(input int n);
        return N'(1) << n;
    endfunction

    function automatic vec_t mk(input logic c, input logic [N-1:0] r, input logic l, input int own, input logic p);
        vec_t v;
        v.clr = c;
        v.req = r;
        v.lock = l;
        v.gnt = (own < 0) ? '0 : b(own);
        v.sel = (own < 0) ? 5'd31 : 5'(own);
        v.busy = own >= 0;
        v.pre = p;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int own, input logic p);
        chk({name, ".gnt"}, 32'(gnt), (own < 0) ? 32'd0 : 32'(b(own)));
        chk({name, ".sel"}, 32'(bus_sel), (own < 0) ? 32'd31 : 32'(own));
        chk({name, ".busy"}, 32'(bus_busy), 32'(own >= 0));
        chk({name, ".preempt"}, 32'(preempt), 32'(p));
    endtask

    task automatic step(input logic c, input logic [N-1:0] r, input logic l);
        clr = c;
        req = r;
        lock = l;
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic model(input logic c, input logic [N-1:0] r, input logic l);
        int p;
        m_pre = 1'b0;
        if (c) begin
            m_owner = -1;
            m_last = N - 1;
            m_hold = 0;
        end else if (m_owner < 0) begin
            p = rr_pick(r, m_last);
            if (p >= 0) begin
                m_owner = p;
                m_last = p;
                m_hold = 1;
            end
        end else if (!r[m_owner]) begin
            p = rr_pick(r, m_last);
            m_owner = p;
            m_last = (p >= 0) ? p : m_last;
            m_hold = (p >= 0) ? 1 : 0;
        end else begin
            p = rr_pick(r & ~b(m_owner), m_last);
            if (m_hold >= MH && !l && p >= 0) begin
                m_owner = p;
                m_last = p;
                m_hold = 1;
                m_pre = 1'b1;
            end else begin
                m_hold = (m_hold >= MH) ? MH : m_hold + 1;
            end
        end
    endtask

    initial begin
        logic [N-1:0] r;
        int srcs[5] = '{0, 5, 11, 20, 23};
        tbl[0] = mk(1, '1, 0, -1, 0);
        tbl[1] = mk(1, '1, 0, -1, 0);
        tbl[2] = mk(0, '1, 0, 0, 0);
        tbl[3] = mk(0, '0, 0, -1, 0);
        tbl[4] = mk(0, b(20), 0, 20, 0);
        tbl[5] = mk(0, b(20), 0, 20, 0);
        tbl[6] = mk(0, b(20), 0, 20, 0);
        tbl[7] = mk(0, '0, 0, -1, 0);
        tbl[8] = mk(0, b(3) | b(21), 0, 21, 0);
        tbl[9] = mk(0, b(3) | b(21), 0, 21, 0);
        tbl[10] = mk(0, b(3) | b(21), 0, 21, 0);
        tbl[11] = mk(0, b(3) | b(21), 0, 21, 0);
        tbl[12] = mk(0, b(3) | b(21), 0, 3, 1);
        tbl[13] = mk(0, b(3) | b(21), 0, 3, 0);
        tbl[14] = mk(0, b(3) | b(21), 0, 3, 0);
        tbl[15] = mk(0, b(3) | b(21), 0, 3, 0);
        tbl[16] = mk(0, b(3) | b(21), 0, 21, 1);
        tbl[17] = mk(0, '0, 0, -1, 0);
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].clr, tbl[i].req, tbl[i].lock);
            chk($sformatf("vec%0d.gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("vec%0d.sel", i), 32'(bus_sel), 32'(tbl[i].sel));
            chk($sformatf("vec%0d.busy", i), 32'(bus_busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d.preempt", i), 32'(preempt), 32'(tbl[i].pre));
        end
        step(1, '0, 0);
        step(0, b(3) | b(21), 0);
        chk_all("lock_first", 3, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, b(3) | b(21), 1);
            chk_all("lock_hold", 3, 0);
        end
        step(0, b(3) | b(21), 0);
        chk_all("lock_release", 21, 1);
        step(0, b(3) | b(21), 0);
        chk_all("lock_after", 21, 0);
        step(1, '0, 0);
        step(0, b(16), 0);
        chk_all("hi_own", 16, 0);
        step(0, b(17), 0);
        chk_all("hi_to_lo", 17, 0);
        step(1, b(17), 0);
        chk_all("clr_mid", -1, 0);
        step(0, b(23), 0);
        chk_all("own23", 23, 0);
        step(0, '0, 0);
        chk_all("idle23", -1, 0);
        step(0, b(0) | b(22), 0);
        chk_all("wrap0", 0, 0);
        step(0, b(22), 0);
        chk_all("then22", 22, 0);
        step(1, '0, 0);
        model(1, '0, 0);
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            logic cc, ll;
            if ($urandom_range(3) == 0) r[srcs[$urandom_range(4)]] ^= 1'b1;
            if ($urandom_range(63) == 0) r = N'($urandom);
            cc = $urandom_range(99) == 0;
            ll = $urandom_range(3) == 0;
            model(cc, r, ll);
            step(cc, r, ll);
            chk_all($sformatf("rand%0d", c), m_owner, m_pre);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
